// File: rtl/parametric_interrupt_controller_if.sv
// Register-access bus of the interrupt controller: select, read/write
// strobes, address, write data, read data/vector and bus-release flag.
interface parametric_interrupt_controller_if;
    logic        chip_select_n;
    logic        write_enable_n;
    logic        read_enable_n;
    logic [2:0]  address;
    logic [31:0] data_bus_in;
    logic [31:0] data_bus_out;
    logic        data_bus_io;

    modport master (
        output chip_select_n, write_enable_n, read_enable_n, address, data_bus_in,
        input  data_bus_out, data_bus_io
    );

    modport slave (
        input  chip_select_n, write_enable_n, read_enable_n, address, data_bus_in,
        output data_bus_out, data_bus_io
    );
endinterface

// File: rtl/parametric_interrupt_controller.sv
// Parametric interrupt controller: synchronised edge/level requests, fixed or
// rotating priority, fully nested in-service tracking, INTA vector handshake.
module parametric_interrupt_controller #(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clock,
    input  logic                              reset_n,
    parametric_interrupt_controller_if.slave  bus,
    input  logic [NUM_IRQ-1:0]                interrupt_request,
    input  logic                              interrupt_acknowledge_n,
    output logic                              interrupt_to_cpu
);
    localparam int ID_W   = 5;           // enough for any id in 0..31
    localparam int RANK_W = 6;           // ranks 0..NUM_IRQ, NUM_IRQ meaning "none"
    localparam int SUM_W  = RANK_W + 1;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_TRIGGER = 3'd2;
    localparam logic [2:0] ADDR_IRR     = 3'd3;
    localparam logic [2:0] ADDR_ISR     = 3'd4;
    localparam logic [2:0] ADDR_EOI     = 3'd5;

    typedef enum logic {IDLE, ACK} state_t;

    state_t              state;
    logic                ctrl_enable;
    logic                ctrl_rotate;
    logic [7:0]          vector_base;
    logic [NUM_IRQ-1:0]  mask;
    logic [NUM_IRQ-1:0]  trigger;
    logic [NUM_IRQ-1:0]  irr;
    logic [NUM_IRQ-1:0]  isr;
    logic [ID_W-1:0]     rotate_ptr;
    logic [7:0]          vector;

    logic [NUM_IRQ-1:0]  sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0]  sync_dly;
    logic [NUM_IRQ-1:0]  sync_out;
    logic [NUM_IRQ-1:0]  edge_set;

    logic [RANK_W-1:0]   rank [NUM_IRQ];
    logic [RANK_W-1:0]   isr_top_rank;
    logic [ID_W-1:0]     isr_top_id;
    logic [RANK_W-1:0]   win_rank;
    logic [ID_W-1:0]     win_id;
    logic [NUM_IRQ-1:0]  eligible;
    logic                win_any;
    logic                isr_any;

    logic                wr_en;
    logic                rd_en;
    logic                ack_take;
    logic                next_idle;
    logic [NUM_IRQ-1:0]  ack_set;
    logic [NUM_IRQ-1:0]  eoi_clear;
    logic                eoi_hit;
    logic [ID_W-1:0]     eoi_id;
    logic [31:0]         isr_wide;
    logic [NUM_IRQ-1:0]  irr_next;
    logic [31:0]         read_data;
    logic                unused_bits;

    // Position of channel id in the current priority order (0 = highest).
    function automatic logic [RANK_W-1:0] rank_of(input int id, input logic rotate,
                                                   input logic [ID_W-1:0] ptr);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(id) + SUM_W'(NUM_IRQ) - SUM_W'(ptr) - SUM_W'(1);
        if (sum >= SUM_W'(NUM_IRQ)) sum = sum - SUM_W'(NUM_IRQ);
        return rotate ? sum[RANK_W-1:0] : RANK_W'(id);
    endfunction

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_set = sync_out & ~sync_dly;

    // Request synchroniser chain plus the delay flop used for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    // NOTE: the synchroniser array is reset like ordinary flops so that no
    // phantom edge appears when reset is released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            sync_dly <= '0;
        end else begin
            sync_q[0] <= interrupt_request;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            sync_dly <= sync_out;
        end
    end

    // Priority resolution: highest in-service rank, then the best eligible request.
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        isr_top_rank = RANK_W'(NUM_IRQ);
        isr_top_id   = '0;
        win_rank     = RANK_W'(NUM_IRQ);
        win_id       = '0;
        eligible     = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            rank[i] = rank_of(i, ctrl_rotate, rotate_ptr);
            if (isr[i] && rank[i] < isr_top_rank) begin
                isr_top_rank = rank[i];
                isr_top_id   = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            eligible[i] = irr[i] & ~mask[i] & (rank[i] < isr_top_rank);
            if (eligible[i] && rank[i] < win_rank) begin
                win_rank = rank[i];
                win_id   = ID_W'(i);
            end
        end
        win_any = |eligible;
        isr_any = |isr;
    end

    assign wr_en     = ~bus.chip_select_n & ~bus.write_enable_n;
    assign rd_en     = ~bus.chip_select_n & ~bus.read_enable_n;
    assign ack_take  = (state == IDLE) & ~interrupt_acknowledge_n;
    assign next_idle = ((state == IDLE) & interrupt_acknowledge_n) |
                       ((state == ACK)  & interrupt_acknowledge_n);
    assign isr_wide  = 32'(isr);

    // End-of-interrupt target: a specific id (if in range and in service) or
    // the highest-priority in-service channel.
    always_comb begin
        eoi_hit   = 1'b0;
        eoi_id    = '0;
        eoi_clear = '0;
        if (wr_en && bus.address == ADDR_EOI) begin
            if (bus.data_bus_in[8]) begin
                if (int'(bus.data_bus_in[4:0]) < NUM_IRQ && isr_wide[bus.data_bus_in[4:0]]) begin
                    eoi_hit = 1'b1;
                    eoi_id  = bus.data_bus_in[4:0];
                end
            end else if (isr_any) begin
                eoi_hit = 1'b1;
                eoi_id  = isr_top_id;
            end
        end
        for (int i = 0; i < NUM_IRQ; i++) eoi_clear[i] = eoi_hit && (eoi_id == ID_W'(i));
    end

    // Acknowledge winner one-hot and next request register value.
    always_comb begin
        ack_set  = '0;
        irr_next = irr;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_set[i] = ack_take && win_any && (win_id == ID_W'(i));
            if (trigger[i])       irr_next[i] = sync_out[i];
            else if (edge_set[i]) irr_next[i] = 1'b1;
            else if (ack_set[i])  irr_next[i] = 1'b0;
        end
    end

    // Registers, in-service tracking, rotation pointer and the IDLE/ACK FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            ctrl_enable      <= 1'b0;
            ctrl_rotate      <= 1'b0;
            vector_base      <= '0;
            mask             <= '1;
            trigger          <= '0;
            irr              <= '0;
            isr              <= '0;
            rotate_ptr       <= ID_W'(NUM_IRQ - 1);
            vector           <= '0;
            interrupt_to_cpu <= 1'b0;
        end else begin
            if (wr_en) begin
                case (bus.address)
                    ADDR_CTRL: begin
                        ctrl_enable <= bus.data_bus_in[0];
                        ctrl_rotate <= bus.data_bus_in[1];
                        vector_base <= bus.data_bus_in[15:8];
                    end
                    ADDR_MASK:    mask    <= bus.data_bus_in[NUM_IRQ-1:0];
                    ADDR_TRIGGER: trigger <= bus.data_bus_in[NUM_IRQ-1:0];
                    default: ;
                endcase
            end
            irr <= irr_next;
            isr <= (isr & ~eoi_clear) | ack_set;
            if (eoi_hit && ctrl_rotate) rotate_ptr <= eoi_id;
            case (state)
                IDLE: if (!interrupt_acknowledge_n) begin
                    state  <= ACK;
                    vector <= win_any ? vector_base + 8'(win_id) : vector_base + 8'(NUM_IRQ);
                end
                ACK: if (interrupt_acknowledge_n) state <= IDLE;
                default: state <= IDLE;
            endcase
            interrupt_to_cpu <= ctrl_enable & win_any & next_idle;
        end
    end

    // Combinational register read mux.
    always_comb begin
        read_data = '0;
        case (bus.address)
            ADDR_CTRL:    read_data = {16'b0, vector_base, 6'b0, ctrl_rotate, ctrl_enable};
            ADDR_MASK:    read_data = 32'(mask);
            ADDR_TRIGGER: read_data = 32'(trigger);
            ADDR_IRR:     read_data = 32'(irr);
            ADDR_ISR:     read_data = 32'(isr);
            default:      read_data = '0;
        endcase
    end

    assign bus.data_bus_io  = ~((state == ACK) | rd_en);
    assign bus.data_bus_out = (state == ACK) ? {24'b0, vector} : (rd_en ? read_data : 32'b0);

    // Write-data bits that no register keeps.
    assign unused_bits = ^bus.data_bus_in;
endmodule

// File: tb/tb_parametric_interrupt_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_parametric_interrupt_controller;
    localparam int N = 16;
    localparam int S = 2;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [N-1:0] irq;
    logic         inta_n;
    logic         int_cpu;
    logic         cmp_en = 1'b0;
    int           checks = 0;
    int           errors = 0;

    parametric_interrupt_controller_if bus_if ();

    parametric_interrupt_controller #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .bus                     (bus_if),
        .interrupt_request       (irq),
        .interrupt_acknowledge_n (inta_n),
        .interrupt_to_cpu        (int_cpu)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_en, m_rot, m_ack, m_int;
    logic [7:0]   m_base, m_vec;
    logic [N-1:0] m_mask, m_trig, m_irr, m_isr, m_dly;
    logic [N-1:0] m_sync [S];
    int           m_ptr;

    function automatic int order_start();
        return m_rot ? (m_ptr + 1) % N : 0;
    endfunction

    // First set bit of v when walking channels in priority order; -1 if none.
    function automatic int first_in(input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            int id;
            id = (order_start() + off) % N;
            if (v[id]) return id;
        end
        return -1;
    endfunction

    // Walk in priority order; an in-service channel met first blocks all below it.
    function automatic int winner_now();
        for (int off = 0; off < N; off++) begin
            int id;
            id = (order_start() + off) % N;
            if (m_isr[id]) return -1;
            if (m_irr[id] && !m_mask[id]) return id;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_reg(input logic [2:0] a);
        case (a)
            3'd0: return {16'b0, m_base, 6'b0, m_rot, m_en};
            3'd1: return 32'(m_mask);
            3'd2: return 32'(m_trig);
            3'd3: return 32'(m_irr);
            3'd4: return 32'(m_isr);
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clock or negedge reset_n) begin : model
        logic [N-1:0] n_irr, n_isr, sync_last, edge_set;
        logic [7:0]   n_vec;
        logic         n_ack, wr;
        int           win, k, n_ptr;
        if (!reset_n) begin
            m_en <= 1'b0; m_rot <= 1'b0; m_base <= '0; m_mask <= '1; m_trig <= '0;
            m_irr <= '0; m_isr <= '0; m_ptr <= N - 1; m_dly <= '0;
            m_ack <= 1'b0; m_vec <= '0; m_int <= 1'b0;
            for (int s = 0; s < S; s++) m_sync[s] <= '0;
        end else begin
            sync_last = m_sync[S-1];
            edge_set  = sync_last & ~m_dly;
            win   = winner_now();
            n_irr = m_irr; n_isr = m_isr; n_ack = m_ack; n_vec = m_vec; n_ptr = m_ptr;
            wr    = !bus_if.chip_select_n && !bus_if.write_enable_n;
            if (wr && bus_if.address == 3'd5) begin
                k = -1;
                if (bus_if.data_bus_in[8]) begin
                    if (int'(bus_if.data_bus_in[4:0]) < N && m_isr[bus_if.data_bus_in[3:0]])
                        k = int'(bus_if.data_bus_in[4:0]);
                end else begin
                    k = first_in(m_isr);
                end
                if (k >= 0) begin
                    n_isr[k] = 1'b0;
                    if (m_rot) n_ptr = k;
                end
            end
            if (!m_ack && !inta_n) begin
                n_ack = 1'b1;
                if (win >= 0) begin
                    n_isr[win] = 1'b1;
                    if (!m_trig[win]) n_irr[win] = 1'b0;
                    n_vec = m_base + 8'(win);
                end else begin
                    n_vec = m_base + 8'(N);
                end
            end else if (m_ack && inta_n) begin
                n_ack = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_trig[i])       n_irr[i] = sync_last[i];
                else if (edge_set[i]) n_irr[i] = 1'b1;
            end
            if (wr && bus_if.address == 3'd0) begin
                m_en <= bus_if.data_bus_in[0]; m_rot <= bus_if.data_bus_in[1];
                m_base <= bus_if.data_bus_in[15:8];
            end
            if (wr && bus_if.address == 3'd1) m_mask <= bus_if.data_bus_in[N-1:0];
            if (wr && bus_if.address == 3'd2) m_trig <= bus_if.data_bus_in[N-1:0];
            m_sync[0] <= irq;
            for (int s = 1; s < S; s++) m_sync[s] <= m_sync[s-1];
            m_dly <= sync_last;
            m_irr <= n_irr; m_isr <= n_isr; m_ptr <= n_ptr;
            m_ack <= n_ack; m_vec <= n_vec;
            m_int <= m_en && (win >= 0) && !n_ack;
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clock) begin : compare
        logic [31:0] exp_out;
        logic        exp_io;
        if (cmp_en) begin
            if (m_ack) begin
                exp_io = 1'b0; exp_out = {24'b0, m_vec};
            end else if (!bus_if.chip_select_n && !bus_if.read_enable_n) begin
                exp_io = 1'b0; exp_out = model_reg(bus_if.address);
            end else begin
                exp_io = 1'b1; exp_out = 32'b0;
            end
            check("cyc_int", 32'(int_cpu), 32'(m_int));
            check("cyc_io", 32'(bus_if.data_bus_io), 32'(exp_io));
            check("cyc_out", bus_if.data_bus_out, exp_out);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_idle();
        bus_if.chip_select_n = 1'b1; bus_if.write_enable_n = 1'b1; bus_if.read_enable_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock); #2;
        bus_if.chip_select_n = 1'b0; bus_if.write_enable_n = 1'b0;
        bus_if.address = a; bus_if.data_bus_in = d;
        @(negedge clock); #2;
        bus_idle();
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clock); #2;
        bus_if.chip_select_n = 1'b0; bus_if.read_enable_n = 1'b0; bus_if.address = a;
        #1 check(name, bus_if.data_bus_out, exp);
        bus_idle();
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        @(negedge clock); #2 irq = irq | bits;
        @(negedge clock); #2 irq = irq & ~bits;
    endtask

    task automatic inta_check(input string name, input logic [31:0] exp);
        @(negedge clock); #2 inta_n = 1'b0;
        @(negedge clock); #1;
        check({name, "_io"}, 32'(bus_if.data_bus_io), 32'd0);
        check(name, bus_if.data_bus_out, exp);
        @(negedge clock); #2 inta_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; irq = '0; inta_n = 1'b1;
        bus_idle(); bus_if.address = '0; bus_if.data_bus_in = '0;
        @(posedge clock); #1 cmp_en = 1'b1;
        check("rst_io", 32'(bus_if.data_bus_io), 32'd1);
        check("rst_int", 32'(int_cpu), 32'd0);
        @(negedge clock); #2 reset_n = 1'b1;
        read_check("rst_mask", 3'd1, 32'h0000_FFFF);
        read_check("rst_ctrl", 3'd0, 32'h0);

        // Edge request 5: latency and vector.
        bus_write(3'd0, 32'h2001);
        bus_write(3'd1, 32'h0);
        @(negedge clock); #2 irq[5] = 1'b1;
        @(negedge clock); #2 irq[5] = 1'b0;
        @(posedge clock); @(posedge clock); #1 check("lat_before", 32'(int_cpu), 32'd0);
        @(posedge clock); #1 check("lat_at", 32'(int_cpu), 32'd1);
        read_check("irr5", 3'd3, 32'h20);
        inta_check("vec5", 32'h25);
        read_check("isr5", 3'd4, 32'h20);
        read_check("irr5_clr", 3'd3, 32'h0);
        bus_write(3'd5, 32'h0);
        read_check("isr5_eoi", 3'd4, 32'h0);

        // Nesting: 3 before 9, 9 held off until 3 is ended.
        pulse(16'h0208); idle(4);
        inta_check("vec3", 32'h23);
        idle(2); check("held9", 32'(int_cpu), 32'd0);
        read_check("irr9", 3'd3, 32'h200);
        bus_write(3'd5, 32'h103); idle(2);
        check("rel9", 32'(int_cpu), 32'd1);
        inta_check("vec9", 32'h29);
        bus_write(3'd5, 32'h0);

        // Rotation.
        bus_write(3'd0, 32'h2003);
        pulse(16'h0004); idle(4);
        inta_check("rot_vec2", 32'h22);
        bus_write(3'd5, 32'h0);
        pulse(16'h000A); idle(4);
        inta_check("rot_vec3", 32'h23);
        bus_write(3'd5, 32'h0); idle(2);
        inta_check("rot_vec1", 32'h21);
        bus_write(3'd5, 32'h0);
        bus_write(3'd0, 32'h2001);

        // Level channel 7 dropped before INTA gives the spurious vector.
        bus_write(3'd2, 32'h80);
        @(negedge clock); #2 irq[7] = 1'b1;
        idle(5); read_check("lvl_on", 3'd3, 32'h80);
        @(negedge clock); #2 irq[7] = 1'b0;
        idle(5); read_check("lvl_off", 3'd3, 32'h0);
        inta_check("spurious", 32'h30);
        read_check("spur_isr", 3'd4, 32'h0);
        bus_write(3'd2, 32'h0);

        // Out-of-range specific EOI and masking.
        pulse(16'h0040); idle(4);
        inta_check("vec6", 32'h26);
        bus_write(3'd5, 32'h114);
        read_check("eoi20", 3'd4, 32'h40);
        bus_write(3'd5, 32'h106);
        read_check("eoi6", 3'd4, 32'h0);
        pulse(16'h0010); idle(4);
        check("irq4_on", 32'(int_cpu), 32'd1);
        bus_write(3'd1, 32'hFFFF); idle(1);
        check("masked", 32'(int_cpu), 32'd0);
        read_check("mask_irr", 3'd3, 32'h10);
        bus_write(3'd1, 32'h0); idle(1);
        check("unmasked", 32'(int_cpu), 32'd1);
        inta_check("vec4", 32'h24);
        bus_write(3'd5, 32'h0);

        // Reset while in ACK.
        pulse(16'h0002); idle(4);
        @(negedge clock); #2 inta_n = 1'b0;
        @(negedge clock); #1;
        check("ack_out", bus_if.data_bus_out, 32'h21);
        #1 reset_n = 1'b0;
        #1;
        check("rack_io", 32'(bus_if.data_bus_io), 32'd1);
        check("rack_int", 32'(int_cpu), 32'd0);
        check("rack_out", bus_if.data_bus_out, 32'h0);
        bus_if.chip_select_n = 1'b0; bus_if.read_enable_n = 1'b0;
        bus_if.address = 3'd0; #1 check("rack_ctrl", bus_if.data_bus_out, 32'h0);
        bus_if.address = 3'd1; #1 check("rack_mask", bus_if.data_bus_out, 32'hFFFF);
        bus_if.address = 3'd3; #1 check("rack_irr", bus_if.data_bus_out, 32'h0);
        bus_if.address = 3'd4; #1 check("rack_isr", bus_if.data_bus_out, 32'h0);
        bus_idle(); inta_n = 1'b1;
        @(negedge clock); #2 reset_n = 1'b1;

        // Randomized traffic against the model.
        bus_write(3'd0, 32'h0000_C001);
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, {16'b0, 16'($urandom)});
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            logic [2:0] a;
            @(negedge clock); #2;
            bus_idle();
            for (int b = 0; b < N; b++) if ($urandom_range(0, 15) == 0) irq[b] = ~irq[b];
            if (inta_n) begin
                if ($urandom_range(0, 7) == 0) inta_n = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                inta_n = 1'b1;
            end
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                a = $urandom_range(0, 1) ? 3'd5 : 3'($urandom_range(0, 7));
                bus_if.chip_select_n = 1'b0; bus_if.write_enable_n = 1'b0; bus_if.address = a;
                case (a)
                    3'd0: bus_if.data_bus_in = {16'($urandom), 8'($urandom), 6'($urandom), 1'($urandom),
                                                1'($urandom_range(0, 5) != 0)};
                    3'd5: bus_if.data_bus_in = {16'($urandom), 7'b0, 1'($urandom), 3'b0, 5'($urandom)};
                    default: bus_if.data_bus_in = $urandom;
                endcase
            end else if (r <= 5) begin
                bus_if.chip_select_n = 1'b0; bus_if.read_enable_n = 1'b0;
                bus_if.address = 3'($urandom_range(0, 7));
            end
        end
        @(negedge clock); #2 bus_idle(); irq = '0; inta_n = 1'b1;
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
